// File: rtl/split_sweep_ctrl_if.sv
// Handshake and result bundle between the sweep sequencer and its host/checker.
// The master side is the sequencer. The slave side is the host that drives
// start/abort and the split checker that returns sat_i.
interface split_sweep_ctrl_if #(
   parameter int W = 8
);
   logic         start;
   logic         abort;
   logic         sat_i;
   logic [W-1:0] assign_o;
   logic         busy;
   logic         done;
   logic [W:0]   sat_count;
   logic [W-1:0] first_sat;
   logic         first_valid;
   logic         all_sat;

   modport master (
      input  start, abort, sat_i,
      output assign_o, busy, done, sat_count, first_sat, first_valid, all_sat
   );

   modport slave (
      output start, abort, sat_i,
      input  assign_o, busy, done, sat_count, first_sat, first_valid, all_sat
   );
endinterface

// File: rtl/split_sweep_ctrl.sv
// Exhaustive sweep sequencer for a combinational split-constraint checker.
// It presents every W-bit assignment once, in ascending order. It counts the
// satisfying assignments and records the lowest one. A sweep completes 2^W+1
// cycles after start is accepted.
module split_sweep_ctrl #(
   parameter int W = 8
) (
   input  logic               clk,
   input  logic               rst,
   split_sweep_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   // 2^W needs the extra count bit; all-ones marks the terminal assignment.
   localparam logic [W:0]   FULL_COUNT = {1'b1, {W{1'b0}}};
   localparam logic [W-1:0] LAST_ASSIGN = '1;

   state_t       state;
   logic [W-1:0] assign_r;
   logic         busy_r;
   logic         done_r;
   logic [W:0]   count_r;
   logic [W-1:0] first_r;
   logic         first_valid_r;
   logic         all_sat_r;
   logic [W:0]   count_next;

   // Running count including the current sample; feeds both the count and the tautology flag.
   always_comb begin
      count_next = count_r + {{W{1'b0}}, bus.sat_i};
   end

   // Sweep FSM. busy/done are registered decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         assign_r      <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         count_r       <= '0;
         first_r       <= '0;
         first_valid_r <= 1'b0;
         all_sat_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               // start beats a simultaneous abort because abort is not looked at here.
               if (bus.start) begin
                  state         <= SWEEP;
                  busy_r        <= 1'b1;
                  assign_r      <= '0;
                  count_r       <= '0;
                  first_r       <= '0;
                  first_valid_r <= 1'b0;
                  all_sat_r     <= 1'b0;
               end
            end
            SWEEP: begin
               if (bus.abort) begin
                  // The current sample is dropped and the partial results are kept.
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else begin
                  count_r <= count_next;
                  if (bus.sat_i && !first_valid_r) begin
                     first_r       <= assign_r;
                     first_valid_r <= 1'b1;
                  end
                  // The terminal compare precedes the increment, so assign_o never wraps.
                  if (assign_r == LAST_ASSIGN) begin
                     state     <= DONE;
                     busy_r    <= 1'b0;
                     done_r    <= 1'b1;
                     all_sat_r <= (count_next == FULL_COUNT);
                  end else begin
                     assign_r <= assign_r + 1'b1;
                  end
               end
            end
            DONE: begin
               // start seen here is dropped, not queued.
               state  <= IDLE;
               done_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.assign_o    = assign_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.sat_count   = count_r;
   assign bus.first_sat   = first_r;
   assign bus.first_valid = first_valid_r;
   assign bus.all_sat     = all_sat_r;
endmodule

// File: tb/tb_split_sweep_ctrl.sv
// Testbench for split_sweep_ctrl. It uses a W=8 instance for directed, random,
// abort and reset sweeps. It uses a W=4 instance for back-to-back sweeps with
// start held high. The expected results come from truth tables scored with
// plain loops.
module tb_split_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   split_sweep_ctrl_if #(.W(8)) bus8 ();
   split_sweep_ctrl_if #(.W(4)) bus4 ();

   split_sweep_ctrl #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   split_sweep_ctrl #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   // The checkers under test are truth tables indexed by the presented assignment.
   bit tt8[256];
   bit tt4[16];
   assign bus8.sat_i = tt8[bus8.assign_o];
   assign bus4.sat_i = tt4[bus4.assign_o];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: count of true entries and the lowest true index (-1 if none).
   function automatic int model_count8();
      int c = 0;
      for (int i = 0; i < 256; i++) c += int'(tt8[i]);
      return c;
   endfunction
   function automatic int model_first8();
      for (int i = 0; i < 256; i++) if (tt8[i]) return i;
      return -1;
   endfunction
   function automatic int model_count4();
      int c = 0;
      for (int i = 0; i < 16; i++) c += int'(tt4[i]);
      return c;
   endfunction
   function automatic int model_first4();
      for (int i = 0; i < 16; i++) if (tt4[i]) return i;
      return -1;
   endfunction

   // Fills tt8 for a directed pattern.
   task automatic fill8(input int mode);
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0:       tt8[i] = 1'b0;
            1:       tt8[i] = 1'b1;
            2:       tt8[i] = (i == 8'hA5) || (i == 8'hF0);
            3:       tt8[i] = (i == 8'hFF);
            default: tt8[i] = (i != 0);
         endcase
      end
   endtask

   // Runs one full W=8 sweep from IDLE. The caller is #1 after a clock edge.
   task automatic run_sweep8(input string tag, input int exp_cnt, input int exp_first,
                             input bit exp_fv, input bit exp_all,
                             input bit abort_with_start, input bit glitch_start);
      bit seq_ok = 1'b1;
      bus8.start = 1'b1;
      bus8.abort = abort_with_start;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.abort = 1'b0;
      check({tag, "_clear_cnt"}, 32'(bus8.sat_count), 0);
      check({tag, "_clear_fv"}, 32'(bus8.first_valid), 0);
      check({tag, "_clear_all"}, 32'(bus8.all_sat), 0);
      for (int k = 1; k <= 256; k++) begin
         if (bus8.assign_o !== 8'(k - 1) || bus8.busy !== 1'b1 || bus8.done !== 1'b0)
            seq_ok = 1'b0;
         bus8.start = glitch_start && (k == 100);
         @(posedge clk); #1;
      end
      bus8.start = 1'b0;
      check({tag, "_sequence"}, 32'(seq_ok), 1);
      check({tag, "_done"}, 32'(bus8.done), 1);
      check({tag, "_busy_at_done"}, 32'(bus8.busy), 0);
      check({tag, "_count"}, 32'(bus8.sat_count), 32'(exp_cnt));
      check({tag, "_first_valid"}, 32'(bus8.first_valid), 32'(exp_fv));
      check({tag, "_first"}, 32'(bus8.first_sat), exp_fv ? 32'(exp_first) : 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(bus8.done), 0);
      check({tag, "_all_sat"}, 32'(bus8.all_sat), 32'(exp_all));
      check({tag, "_idle_busy"}, 32'(bus8.busy), 0);
   endtask

   typedef struct {
      int mode;
      int exp_cnt;
      int exp_first;
      bit exp_fv;
      bit exp_all;
   } vec_t;

   vec_t vecs[5];

   initial begin
      bit done_seen;
      bit busy_seen;
      int ndone;
      int cyc;
      int last;
      int exp_c4;
      int exp_f4;
      bit pending_all;
      bit exp_all4;

      vecs[0] = '{1, 256, 8'h00, 1'b1, 1'b1};
      vecs[1] = '{2, 2,   8'hA5, 1'b1, 1'b0};
      vecs[2] = '{0, 0,   8'h00, 1'b0, 1'b0};
      vecs[3] = '{3, 1,   8'hFF, 1'b1, 1'b0};
      vecs[4] = '{4, 255, 8'h01, 1'b1, 1'b0};

      bus8.start = 1'b0; bus8.abort = 1'b0;
      bus4.start = 1'b0; bus4.abort = 1'b0;
      fill8(0);
      for (int i = 0; i < 16; i++) tt4[i] = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_assign", 32'(bus8.assign_o), 0);
      check("rst_busy", 32'(bus8.busy), 0);
      check("rst_done", 32'(bus8.done), 0);
      check("rst_count", 32'(bus8.sat_count), 0);
      check("rst_first", 32'(bus8.first_sat), 0);
      check("rst_fv", 32'(bus8.first_valid), 0);
      check("rst_all", 32'(bus8.all_sat), 0);
      check("rst4_busy", 32'(bus4.busy), 0);
      check("rst4_count", 32'(bus4.sat_count), 0);

      // Directed table of truth-table patterns
      for (int v = 0; v < 5; v++) begin
         fill8(vecs[v].mode);
         run_sweep8($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_first,
                    vecs[v].exp_fv, vecs[v].exp_all, 1'b0, 1'b0);
      end

      // Random truth tables against the model, with mid-sweep start and start+abort
      for (int r = 0; r < 4; r++) begin
         int thr = $urandom_range(0, 100);
         int f;
         for (int i = 0; i < 256; i++) tt8[i] = ($urandom_range(0, 99) < thr);
         f = model_first8();
         run_sweep8($sformatf("rnd%0d", r), model_count8(), (f < 0) ? 0 : f, f >= 0,
                    model_count8() == 256, r[1], r[0]);
      end

      // Abort in SWEEP cycle 10
      fill8(1);
      bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("abort_assign", 32'(bus8.assign_o), 32'h09);
      bus8.abort = 1'b1;
      @(posedge clk); #1;
      bus8.abort = 1'b0;
      check("abort_busy", 32'(bus8.busy), 0);
      check("abort_count", 32'(bus8.sat_count), 9);
      check("abort_fv", 32'(bus8.first_valid), 1);
      check("abort_first", 32'(bus8.first_sat), 0);
      check("abort_all", 32'(bus8.all_sat), 0);
      done_seen = 1'b0;
      busy_seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         bus8.abort = $urandom_range(0, 1);
         done_seen |= bus8.done;
         busy_seen |= bus8.busy;
         @(posedge clk); #1;
      end
      bus8.abort = 1'b0;
      check("abort_no_done", 32'(done_seen), 0);
      check("abort_idle_busy", 32'(busy_seen), 0);
      check("abort_held_count", 32'(bus8.sat_count), 9);
      run_sweep8("after_abort", 256, 0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-sweep at assign_o = 0x40
      bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (64) begin @(posedge clk); #1; end
      check("mid_assign", 32'(bus8.assign_o), 32'h40);
      #3 rst = 1'b1;
      #1;
      check("arst_assign", 32'(bus8.assign_o), 0);
      check("arst_busy", 32'(bus8.busy), 0);
      check("arst_done", 32'(bus8.done), 0);
      check("arst_count", 32'(bus8.sat_count), 0);
      check("arst_fv", 32'(bus8.first_valid), 0);
      check("arst_all", 32'(bus8.all_sat), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      done_seen = 1'b0;
      busy_seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         done_seen |= bus8.done;
         busy_seen |= bus8.busy;
         @(posedge clk); #1;
      end
      check("arst_no_done", 32'(done_seen), 0);
      check("arst_no_busy", 32'(busy_seen), 0);
      fill8(2);
      run_sweep8("after_rst", 2, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

      // W=4 back-to-back sweeps with start held high
      for (int i = 0; i < 16; i++) tt4[i] = ($urandom_range(0, 1) == 1);
      exp_c4 = model_count4();
      exp_f4 = model_first4();
      ndone = 0;
      cyc = 0;
      last = 0;
      pending_all = 1'b0;
      exp_all4 = 1'b0;
      bus4.start = 1'b1;
      while (cyc < 200 && !(ndone >= 6 && !pending_all)) begin
         @(posedge clk); #1;
         cyc++;
         if (pending_all) begin
            check($sformatf("w4_all_sat%0d", ndone), 32'(bus4.all_sat), 32'(exp_all4));
            pending_all = 1'b0;
         end
         if (bus4.done === 1'b1) begin
            ndone++;
            if (ndone == 1) check("w4_first_latency", 32'(cyc), 17);
            else check($sformatf("w4_spacing%0d", ndone), 32'(cyc - last), 18);
            last = cyc;
            check($sformatf("w4_count%0d", ndone), 32'(bus4.sat_count), 32'(exp_c4));
            check($sformatf("w4_fv%0d", ndone), 32'(bus4.first_valid), 32'(exp_f4 >= 0));
            check($sformatf("w4_first%0d", ndone), 32'(bus4.first_sat),
                  (exp_f4 < 0) ? 0 : 32'(exp_f4));
            exp_all4 = (exp_c4 == 16);
            pending_all = 1'b1;
            // The next sweep's checker is swapped in during DONE, before it is first sampled.
            for (int i = 0; i < 16; i++)
               tt4[i] = (ndone == 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
            exp_c4 = model_count4();
            exp_f4 = model_first4();
         end
      end
      bus4.start = 1'b0;
      check("w4_done_count", 32'(ndone), 6);
      repeat (20) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
